// File: rtl/buf_fill_ctrl.sv
// Window-buffer fill controller: loads WORDS words per row into a shift-register window, presents it, repeats for ROWS rows.
// Latency: wr_en/sh_up are combinational with acceptance; out_valid rises the cycle after the row's last word is accepted.
// Backpressure: in_ready only in LOAD; out_valid holds in PRESENT until out_ready; stalls of any length freeze state and counters.
module buf_fill_ctrl #(
    parameter int WORDS = 4,
    parameter int ROWS  = 16,
    parameter int ADR_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic             sh_up,
    output logic [ADR_W-1:0] adr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int ROW_W  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PRESENT = 2'd2,
        S_FIN     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  row;
    logic [WORD_W-1:0] word;
    logic              accept;
    logic              consume;

    // Abort masks both handshakes so a cancelled cycle never moves the window.
    assign accept  = (state == S_LOAD)    && in_valid  && !abort;
    assign consume = (state == S_PRESENT) && out_ready && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept && (word == WORD_LAST)) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (consume) begin
                    state_nxt = (row == ROW_LAST) ? S_FIN : S_LOAD;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Row stays at its last value through FIN so adr is steady until the job ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            word <= '0;
        end else if (state == S_IDLE || abort) begin
            row  <= '0;
            word <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        word <= (word == WORD_LAST) ? '0 : word + WORD_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (consume && (row != ROW_LAST)) begin
                        row <= row + ROW_W'(1);
                    end
                end
                S_FIN: begin
                    row  <= '0;
                    word <= '0;
                end
                default: begin
                    row  <= row;
                    word <= word;
                end
            endcase
        end
    end

    // Outputs decode state only (plus the masked handshakes), so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state == S_LOAD);
        wr_en     = accept;
        sh_up     = accept;
        out_valid = (state == S_PRESENT);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN) && !abort;
    end

    assign adr = ADR_W'(row);

endmodule

// File: tb/tb_buf_fill_ctrl.sv
// Bench for buf_fill_ctrl: per-cycle vector table on a WORDS=4/ROWS=2 instance, plus async-reset and ROWS=1 sequences.
module tb_buf_fill_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start, abort, in_valid, out_ready;
    logic       in_ready, wr_en, sh_up, out_valid, busy, done;
    logic [8:0] adr;

    logic       s1_start, s1_abort, s1_in_valid, s1_out_ready;
    logic       s1_in_ready, s1_wr_en, s1_sh_up, s1_out_valid, s1_busy, s1_done;
    logic [8:0] s1_adr;

    int errors = 0;
    int checks = 0;

    buf_fill_ctrl #(.WORDS(4), .ROWS(2), .ADR_W(9)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .sh_up(sh_up),
        .adr(adr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    buf_fill_ctrl #(.WORDS(4), .ROWS(1), .ADR_W(9)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .wr_en(s1_wr_en), .sh_up(s1_sh_up),
        .adr(s1_adr), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .busy(s1_busy), .done(s1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic       ab;
        logic       iv;
        logic       ordy;
        logic       ir;
        logic       we;
        logic       ov;
        logic       bz;
        logic       dn;
        logic [8:0] adr;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t v(input logic st, ab, iv, ordy, ir, we, ov, bz, dn, input int a);
        vec_t r;
        r.st = st; r.ab = ab; r.iv = iv; r.ordy = ordy;
        r.ir = ir; r.we = we; r.ov = ov; r.bz = bz; r.dn = dn;
        r.adr = 9'(a);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {in_ready, wr_en, sh_up, out_valid, busy, done, adr}
    function automatic logic [31:0] pack_main();
        return {17'd0, in_ready, wr_en, sh_up, out_valid, busy, done, adr};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt, dn_cnt, ov_cnt, adr_bad;
        bit seen_done;
        logic [31:0] expv;

        //          st ab iv or  ir we ov bz dn adr
        vecs[0]  = v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // idle after reset
        vecs[1]  = v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // start
        vecs[2]  = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[3]  = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[4]  = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[5]  = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);   // 4th word
        vecs[6]  = v(0, 0, 1, 1,  0, 0, 1, 1, 0, 0);   // present row 0, consumed
        vecs[7]  = v(0, 0, 1, 1,  1, 1, 0, 1, 0, 1);
        vecs[8]  = v(0, 0, 1, 1,  1, 1, 0, 1, 0, 1);
        vecs[9]  = v(0, 0, 1, 1,  1, 1, 0, 1, 0, 1);
        vecs[10] = v(0, 0, 1, 1,  1, 1, 0, 1, 0, 1);
        vecs[11] = v(0, 0, 0, 1,  0, 0, 1, 1, 0, 1);   // present row 1, consumed
        vecs[12] = v(0, 0, 0, 1,  0, 0, 0, 1, 1, 1);   // FIN
        vecs[13] = v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[14] = v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // second job, upstream gaps
        vecs[15] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[16] = v(0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[17] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[18] = v(0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[19] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[20] = v(0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[21] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);   // 4th accepted word
        vecs[22] = v(0, 0, 1, 0,  0, 0, 1, 1, 0, 0);   // downstream stall 1, in_valid ignored
        vecs[23] = v(1, 0, 1, 0,  0, 0, 1, 1, 0, 0);   // start while busy ignored
        vecs[24] = v(0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
        vecs[25] = v(0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
        vecs[26] = v(0, 0, 0, 0,  0, 0, 1, 1, 0, 0);   // stall 5
        vecs[27] = v(0, 0, 0, 1,  0, 0, 1, 1, 0, 0);   // consume row 0
        vecs[28] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 1);
        vecs[29] = v(0, 0, 1, 0,  1, 1, 0, 1, 0, 1);   // 2 words of row 1
        vecs[30] = v(0, 1, 1, 0,  1, 0, 0, 1, 0, 1);   // abort beats acceptance
        vecs[31] = v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[32] = v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // restart
        vecs[33] = v(0, 0, 0, 0,  1, 0, 0, 1, 0, 0);   // back at adr 0
        vecs[34] = v(1, 0, 1, 0,  1, 1, 0, 1, 0, 0);   // start while busy, word accepted

        rst_n = 1'b0;
        start = 0; abort = 0; in_valid = 0; out_ready = 0;
        s1_start = 0; s1_abort = 0; s1_in_valid = 0; s1_out_ready = 0;
        #3;
        chk("reset_outputs", pack_main(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            start     = vecs[i].st;
            abort     = vecs[i].ab;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            #2;
            expv = {17'd0, vecs[i].ir, vecs[i].we, vecs[i].we, vecs[i].ov,
                    vecs[i].bz, vecs[i].dn, vecs[i].adr};
            chk($sformatf("vec%0d", i), pack_main(), expv);
        end

        // Asynchronous reset mid-LOAD, between clock edges, with start and in_valid held.
        @(negedge clk);
        start = 1; in_valid = 1; abort = 0; out_ready = 0;
        #1;
        chk("preload_wr_en", {31'd0, wr_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", pack_main(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        start = 0; in_valid = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("idle_after_reset", pack_main(), 32'd0);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        #2;
        chk("fresh_start_load", pack_main(), {17'd0, 6'b100010, 9'd0});
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        #2;
        chk("abort_to_idle", pack_main(), 32'd0);

        // ROWS=1: one row, then done; adr stays at 0 throughout.
        wr_cnt = 0; dn_cnt = 0; ov_cnt = 0; adr_bad = 0; seen_done = 0;
        @(negedge clk);
        s1_start = 1;
        @(negedge clk);
        s1_start = 0; s1_in_valid = 1; s1_out_ready = 1;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            #2;
            if (s1_wr_en) wr_cnt++;
            if (s1_out_valid) ov_cnt++;
            if (s1_adr != 9'd0) adr_bad++;
            if (s1_done) begin
                dn_cnt++;
                seen_done = 1;
            end
            @(negedge clk);
        end
        #2;
        if (s1_done) dn_cnt++;
        chk("rows1_done_seen", {31'd0, seen_done}, 32'd1);
        chk("rows1_wr_count", wr_cnt, 32'd4);
        chk("rows1_present_cycles", ov_cnt, 32'd1);
        chk("rows1_done_count", dn_cnt, 32'd1);
        chk("rows1_adr_nonzero", adr_bad, 32'd0);
        chk("rows1_idle_busy", {31'd0, s1_busy}, 32'd0);
        s1_in_valid = 0; s1_out_ready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buf_fill_ctrl.md
BUF_FILL_CTRL -- requirements
Module: buf_fill_ctrl

Interface
REQ-001 Parameter WORDS, default 4: words per window fill, which is the depth of the shift-register window buffer.
REQ-002 Parameter ROWS, default 16: number of windows per job (must be ≥1).
REQ-003 Parameter ADR_W, default 9: width of the buffer address.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: begin a job; sampled in IDLE only.
REQ-007 Port abort, input, 1: synchronous job cancel.
REQ-008 Port in_valid, input, 1: upstream word available.
REQ-009 Port in_ready, output, 1: controller accepts a word this cycle.
REQ-010 Port wr_en, output, 1: window-buffer slot-0 write strobe.
REQ-011 Port sh_up, output, 1: window-buffer shift-up strobe.
REQ-012 Port adr, output, ADR_W: current row address to the buffers.
REQ-013 Port out_valid, output, 1: full window presented downstream.
REQ-014 Port out_ready, input, 1: downstream consumes the window.
REQ-015 Port busy, output, 1: the FSM is not in IDLE.
REQ-016 Port done, output, 1: one-cycle job-complete pulse.

Function
REQ-017 FSM states are IDLE, LOAD, PRESENT and FIN; the state, row counter and word counter are registers.
REQ-018 IDLE with start=1 -> LOAD next cycle, with row=0 and word=0.
REQ-019 In LOAD, in_ready=1; in all other states in_ready=0, and in_valid is ignored.
REQ-020 Word acceptance (in_valid & in_ready):
- wr_en=1 and sh_up=1, combinationally, in the same cycle.
- Effect: older words move up one slot and the new word lands in slot 0.
REQ-021 Outside acceptance cycles, wr_en=0 and sh_up=0; the two are never asserted independently.
REQ-022 The word counter increments on each acceptance; the acceptance with word==WORDS-1 clears word to 0 and moves the FSM to PRESENT.
REQ-023 In PRESENT, out_valid=1 and is held until out_ready=1; the window is consumed on the cycle where out_valid & out_ready.
REQ-024 On consume with row<ROWS-1: row increments and the FSM returns to LOAD.
REQ-025 On consume with row==ROWS-1: the FSM goes to FIN.
REQ-026 FIN lasts exactly one cycle with done=1, then goes to IDLE; row resets to 0.
REQ-027 adr equals the row counter zero-extended to ADR_W, and is stable for the whole of LOAD and PRESENT of that row.
REQ-028 busy=1 in LOAD, PRESENT and FIN.
REQ-029 start is ignored while busy.
REQ-030 abort=1 in any non-IDLE state:
- next state is IDLE, counters clear, done is not pulsed;
- abort takes priority over a simultaneous acceptance or consume, and no wr_en/sh_up is issued that cycle.
REQ-031 Upstream stalls (in_valid=0) and downstream stalls (out_ready=0) of any length leave state and counters unchanged.
REQ-032 No combinational path exists from out_ready to in_ready; the controller never accepts a word while in PRESENT.

Reset
REQ-033 While rst_n=0, immediately and asynchronously: state=IDLE, row=0, word=0, and in_ready, wr_en, sh_up, out_valid, busy and done are 0.
REQ-034 rst_n asserted mid-job discards the job; after release the block waits in IDLE for a fresh start.

Verification
REQ-035 Basic job (WORDS=4, ROWS=2): start, then 8 back-to-back valid words, out_ready=1 -> exactly 8 wr_en/sh_up pulses, out_valid high 1 cycle per row, adr 0 then 1, done pulse 1 cycle after the 2nd consume.
REQ-036 Upstream gaps: in_valid toggling 1,0,1,0… -> wr_en only on accepted cycles, PRESENT entered only after the 4th accepted word.
REQ-037 Downstream backpressure: out_ready=0 for 5 cycles in PRESENT -> out_valid held 5+ cycles, in_ready=0 throughout, adr unchanged.
REQ-038 Abort after 2 words of row 1 -> IDLE next cycle, busy=0, no done; a new start restarts at adr=0.
REQ-039 rst_n pulsed low mid-LOAD between clock edges -> all outputs 0 immediately; start asserted during busy (before the reset) has no effect.
REQ-040 ROWS=1 boundary -> a single row, then done; adr never exceeds 0.
